write_buffer: RTL

- Output-side counterpart of the pixel read path. Collects processed 24-bit pixels from the cartoonify filter pipeline into a DEPTH-entry buffer.
- Drains the buffer to SDRAM as 32-bit Avalon-MM master single-word writes at consecutive word addresses.
- Sits between the filter core (pixel_valid/pixel_ready handshake) and the Avalon master write port.

---
 rtl/write_buffer.sv | 82 ++++++++
 1 files changed

// File: rtl/write_buffer.sv
// write_buffer: collects DEPTH filtered 24-bit pixels, then drains them as
// single-word Avalon-MM writes to consecutive addresses.
module write_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int STRIDE = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              pixel_valid,
  input  logic [23:0]       pixel_in,
  output logic              pixel_ready,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              load_addr,
  input  logic              flush,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_write,
  output logic [31:0]       master_writedata,
  input  logic              master_waitrequest,
  output logic              done_write,
  output logic              buffer_empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t            r_state, w_next;
  logic [23:0]       r_buf [DEPTH];
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_rd_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic              w_hs, w_ack, w_last, w_full;

  assign pixel_ready      = (r_state == IDLE) || (r_state == FILL && r_count < CW'(DEPTH));
  assign w_hs             = pixel_valid && pixel_ready;
  assign w_ack            = (r_state == WRITE) && !master_waitrequest;
  assign w_last           = (CW'(r_rd_ptr) == r_count - CW'(1));
  assign w_full           = w_hs && (r_count == CW'(DEPTH - 1));
  assign master_write     = (r_state == WRITE);
  assign master_writedata = master_write ? {8'h00, r_buf[r_rd_ptr]} : 32'h0;
  assign master_address   = r_addr;
  assign done_write       = (r_state == DONE);
  assign buffer_empty     = (r_count == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_hs ? (flush ? WRITE : FILL) : IDLE;
      FILL:    w_next = (flush || w_full) ? WRITE : FILL;
      WRITE:   w_next = (w_ack && w_last) ? DONE : WRITE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_addr   <= '0;
    end else begin
      r_state <= w_next;
      if (w_hs) r_count <= r_count + CW'(1);
      if (r_state == DONE) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
      end
      // Address only moves on accepted words, so it carries over between bursts.
      if (w_ack) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_addr   <= r_addr + ADDR_W'(STRIDE);
      end else if (load_addr && (r_state == IDLE || r_state == FILL)) begin
        r_addr <= start_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) r_buf[r_count[PW-1:0]] <= pixel_in;
  end
endmodule
